// File: rtl/eeprom_cmd_engine.sv
// Byte-level serial EEPROM command engine: control byte decode, word address capture, page-wrapped writes, prefetched reads.
// Latency: ack_out and mem_we/mem_re one cycle after the byte/request, tx_valid two cycles after a read trigger.
// Backpressure: none; the front-end spaces bus events >=4 clk apart and tx_req is honoured only while tx_valid is set.
module eeprom_cmd_engine #(
  parameter int         ADDR_WIDTH  = 13,
  parameter int         PAGE_BITS   = 5,
  parameter logic [3:0] DEVICE_TYPE = 4'b1010
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  rx_valid,
  input  logic [7:0]            rx_byte,
  output logic                  ack_out,
  input  logic                  tx_req,
  input  logic                  tx_nack,
  output logic [7:0]            tx_byte,
  output logic                  tx_valid,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [7:0]            mem_wdata,
  output logic                  mem_we,
  output logic                  mem_re,
  input  logic [7:0]            mem_rdata
);

  typedef enum logic [2:0] {
    ST_IDLE, ST_CTRL, ST_ADDR_HI, ST_ADDR_LO, ST_WRITE, ST_READ, ST_WAIT
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = 1;
  localparam logic [PAGE_BITS-1:0]  PAGE_ONE = 1;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  ack_q, ack_d;
  logic [7:0]            tx_byte_q, tx_byte_d;
  logic                  tx_vld_q, tx_vld_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [7:0]            mem_wdata_q, mem_wdata_d;
  logic                  mem_we_q, mem_we_d;
  logic                  mem_re_q, mem_re_d;
  logic                  rd_pend_q, rd_pend_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr_q      <= '0;
      ack_q       <= 1'b0;
      tx_byte_q   <= 8'h00;
      tx_vld_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= 8'h00;
      mem_we_q    <= 1'b0;
      mem_re_q    <= 1'b0;
      rd_pend_q   <= 1'b0;
    end else begin
      addr_q      <= addr_d;
      ack_q       <= ack_d;
      tx_byte_q   <= tx_byte_d;
      tx_vld_q    <= tx_vld_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_we_q    <= mem_we_d;
      mem_re_q    <= mem_re_d;
      rd_pend_q   <= rd_pend_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    ack_d       = ack_q;
    tx_byte_d   = tx_byte_q;
    tx_vld_d    = tx_vld_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_we_d    = 1'b0;
    mem_re_d    = 1'b0;
    // RAM data lands the cycle after mem_re; capture it one edge later.
    rd_pend_d   = mem_re_q;

    if (rd_pend_q) begin
      tx_byte_d = mem_rdata;
      tx_vld_d  = 1'b1;
    end

    if (stop) begin
      state_d   = ST_IDLE;
      ack_d     = 1'b0;
      tx_vld_d  = 1'b0;
      rd_pend_d = 1'b0;
    end else if (start) begin
      state_d   = ST_CTRL;
      ack_d     = 1'b0;
      tx_vld_d  = 1'b0;
      rd_pend_d = 1'b0;
    end else begin
      case (state_q)
        ST_CTRL: begin
          if (rx_valid) begin
            if (rx_byte[7:4] != DEVICE_TYPE) begin
              ack_d   = 1'b0;
              state_d = ST_WAIT;
            end else begin
              ack_d = 1'b1;
              if (rx_byte[0]) begin
                state_d    = ST_READ;
                mem_re_d   = 1'b1;
                mem_addr_d = addr_q;
              end else begin
                state_d = ST_ADDR_HI;
              end
            end
          end
        end
        ST_ADDR_HI: begin
          if (rx_valid) begin
            addr_d[ADDR_WIDTH-1:8] = rx_byte[ADDR_WIDTH-9:0];
            ack_d                  = 1'b1;
            state_d                = ST_ADDR_LO;
          end
        end
        ST_ADDR_LO: begin
          if (rx_valid) begin
            addr_d[7:0] = rx_byte;
            ack_d       = 1'b1;
            state_d     = ST_WRITE;
          end
        end
        ST_WRITE: begin
          if (rx_valid) begin
            mem_we_d    = 1'b1;
            mem_addr_d  = addr_q;
            mem_wdata_d = rx_byte;
            ack_d       = 1'b1;
            // Only the in-page offset advances, so long bursts wrap within the page.
            addr_d[PAGE_BITS-1:0] = addr_q[PAGE_BITS-1:0] + PAGE_ONE;
          end
        end
        ST_READ: begin
          if (tx_nack) begin
            state_d = ST_WAIT;
          end else if (tx_req && tx_vld_q) begin
            tx_vld_d   = 1'b0;
            addr_d     = addr_q + ADDR_ONE;
            mem_addr_d = addr_q + ADDR_ONE;
            mem_re_d   = 1'b1;
          end
          if (rx_valid) ack_d = 1'b0;
        end
        default: begin
          // IDLE and WAIT never acknowledge a byte.
          if (rx_valid) ack_d = 1'b0;
        end
      endcase
    end
  end

  assign ack_out   = ack_q;
  assign tx_byte   = tx_byte_q;
  assign tx_valid  = tx_vld_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_we    = mem_we_q;
  assign mem_re    = mem_re_q;

endmodule

// File: tb/tb_eeprom_cmd_engine.sv
// Bench for eeprom_cmd_engine: directed scenarios plus random transactions against a byte-array EEPROM model.
module tb_eeprom_cmd_engine;
  localparam int AW    = 13;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          start, stop, rx_valid, tx_req, tx_nack;
  logic [7:0]    rx_byte;
  logic          ack_out, tx_valid, mem_we, mem_re;
  logic [7:0]    tx_byte, mem_wdata, mem_rdata;
  logic [AW-1:0] mem_addr;

  always #5 clk = ~clk;

  eeprom_cmd_engine dut (
    .clk(clk), .reset_n(reset_n), .start(start), .stop(stop),
    .rx_valid(rx_valid), .rx_byte(rx_byte), .ack_out(ack_out),
    .tx_req(tx_req), .tx_nack(tx_nack), .tx_byte(tx_byte), .tx_valid(tx_valid),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
    .mem_rdata(mem_rdata)
  );

  // Synchronous backing RAM with a preload port for the bench.
  logic [7:0]    ram [0:DEPTH-1];
  logic          pl_we;
  logic [AW-1:0] pl_addr;
  logic [7:0]    pl_dat;
  always @(posedge clk) begin
    if (pl_we) ram[pl_addr] <= pl_dat;
    else if (mem_we) ram[mem_addr] <= mem_wdata;
    if (mem_re) mem_rdata <= ram[mem_addr];
  end

  // Every cycle with mem_we high is logged; a stretched strobe shows up as an extra write.
  logic [AW+7:0] obs_q[$];
  always @(negedge clk) if (mem_we) obs_q.push_back({mem_addr, mem_wdata});

  // Reference model: EEPROM contents, current address, expected write log.
  logic [7:0]    model_mem [0:DEPTH-1];
  int            m_addr = 0;
  logic [AW+7:0] exp_q[$];
  int            obs_rd = 0;

  int            n_chk = 0, n_fail = 0;
  logic [7:0]    wr_buf [0:7];
  logic [7:0]    hi, lo;
  int            n;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int k);
    repeat (k) tick();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_chk++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic [7:0] jit();
    return 8'($urandom_range(0, 7)) << 1;
  endfunction

  task automatic pulse_start();
    start = 1'b1; tick(); start = 1'b0; idle(3);
  endtask

  task automatic pulse_stop();
    stop = 1'b1; tick(); stop = 1'b0; idle(3);
  endtask

  task automatic send(input logic [7:0] b, input logic exp_ack, input string tag);
    rx_byte = b; rx_valid = 1'b1; tick(); rx_valid = 1'b0;
    chk(tag, ack_out, exp_ack);
    idle(3);
  endtask

  task automatic m_set_addr(input logic [7:0] h, input logic [7:0] l);
    m_addr = ((int'(h) % 32) * 256) + int'(l);
  endtask

  task automatic m_write(input logic [7:0] b);
    exp_q.push_back({AW'(m_addr), b});
    model_mem[m_addr] = b;
    m_addr = (m_addr / 32) * 32 + ((m_addr + 1) % 32);
  endtask

  task automatic check_writes(input string tag);
    chk({tag, "_count"}, obs_q.size() - obs_rd, exp_q.size());
    for (int i = 0; i < exp_q.size() && (obs_rd + i) < obs_q.size(); i++)
      chk(tag, 32'(obs_q[obs_rd + i]), 32'(exp_q[i]));
    obs_rd = obs_q.size();
    exp_q.delete();
  endtask

  task automatic wr_txn(input logic [7:0] h, input logic [7:0] l, input int cnt);
    pulse_start();
    send(8'hA0 | jit(), 1'b1, "ctrl_w");
    send(h, 1'b1, "addr_hi");
    send(l, 1'b1, "addr_lo");
    m_set_addr(h, l);
    for (int i = 0; i < cnt; i++) begin
      send(wr_buf[i], 1'b1, "wdata_ack");
      m_write(wr_buf[i]);
    end
    pulse_stop();
    check_writes("write");
  endtask

  // Read cnt bytes from the current address; the caller has already issued start.
  task automatic rd_cur(input int cnt);
    send(8'hA1 | jit(), 1'b1, "ctrl_r");
    chk("rd_valid", tx_valid, 1'b1);
    chk("rd_byte", tx_byte, model_mem[m_addr]);
    for (int i = 1; i < cnt; i++) begin
      tx_req = 1'b1; tick(); tx_req = 1'b0;
      chk("rd_valid_drop", tx_valid, 1'b0);
      idle(3);
      m_addr = (m_addr + 1) % DEPTH;
      chk("rd_valid", tx_valid, 1'b1);
      chk("rd_byte", tx_byte, model_mem[m_addr]);
    end
    tx_nack = 1'b1; tick(); tx_nack = 1'b0; idle(3);
    pulse_stop();
    chk("rd_stop_valid", tx_valid, 1'b0);
  endtask

  initial begin
    reset_n = 1'b0; start = 1'b0; stop = 1'b0; rx_valid = 1'b0; rx_byte = 8'h00;
    tx_req = 1'b0; tx_nack = 1'b0; pl_we = 1'b0; pl_addr = '0; pl_dat = 8'h00;

    for (int i = 0; i < DEPTH; i++) begin
      pl_we = 1'b1; pl_addr = AW'(i); pl_dat = 8'($urandom);
      model_mem[i] = pl_dat;
      tick();
    end
    pl_we = 1'b0;

    chk("rst_ack", ack_out, 1'b0);
    chk("rst_tx_valid", tx_valid, 1'b0);
    chk("rst_tx_byte", tx_byte, 8'h00);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 8'h00);
    chk("rst_mem_we", mem_we, 1'b0);
    chk("rst_mem_re", mem_re, 1'b0);
    reset_n = 1'b1; idle(2);
    chk("post_rst_we", mem_we, 1'b0);

    // Single byte write to 0x0123.
    wr_buf[0] = 8'h5A;
    wr_txn(8'h01, 8'h23, 1);
    // Page wrap: 0x003E, 0x003F, 0x0020.
    wr_buf[0] = 8'h11; wr_buf[1] = 8'h22; wr_buf[2] = 8'h33;
    wr_txn(8'h00, 8'h3E, 3);
    // Seed the random-read targets.
    wr_buf[0] = 8'hC3; wr_txn(8'h1F, 8'hFF, 1);
    wr_buf[0] = 8'h7E; wr_txn(8'h00, 8'h00, 1);

    // Random read at 0x1FFF with exact prefetch timing, then wrap to 0x0000.
    pulse_start();
    send(8'hA0, 1'b1, "rr_ctrl_w");
    send(8'h1F, 1'b1, "rr_hi");
    send(8'hFF, 1'b1, "rr_lo");
    pulse_start();
    rx_byte = 8'hA1; rx_valid = 1'b1; tick(); rx_valid = 1'b0;
    chk("rr_ack", ack_out, 1'b1);
    chk("rr_mem_re", mem_re, 1'b1);
    chk("rr_mem_addr", mem_addr, 13'h1FFF);
    tick();
    chk("rr_valid_t1", tx_valid, 1'b0);
    tick();
    chk("rr_valid_t2", tx_valid, 1'b1);
    chk("rr_byte0", tx_byte, 8'hC3);
    idle(2);
    tx_req = 1'b1; tick(); tx_req = 1'b0;
    chk("rr_valid_drop", tx_valid, 1'b0);
    chk("rr_wrap_addr", mem_addr, 0);
    idle(2);
    chk("rr_valid_next", tx_valid, 1'b1);
    chk("rr_byte1", tx_byte, 8'h7E);
    idle(2);
    tx_nack = 1'b1; tick(); tx_nack = 1'b0; idle(3);
    pulse_stop();
    chk("rr_stop_valid", tx_valid, 1'b0);
    m_addr = 0;
    send(8'hA0, 1'b0, "idle_ignores");
    check_writes("idle_no_write");

    // Wrong device type: NACK, and the next byte is ignored until start.
    pulse_start();
    send(8'h50, 1'b0, "bad_ctrl");
    send(8'h12, 1'b0, "wait_byte");
    check_writes("wait_no_write");
    pulse_start();
    chk("start_clears_ack", ack_out, 1'b0);
    send(8'hA0, 1'b1, "ctrl_after_wait");
    pulse_stop();

    // stop wins over a coinciding data byte.
    pulse_start();
    send(8'hA0, 1'b1, "sr_ctrl");
    send(8'h04, 1'b1, "sr_hi");
    send(8'h10, 1'b1, "sr_lo");
    m_set_addr(8'h04, 8'h10);
    rx_byte = 8'h99; rx_valid = 1'b1; stop = 1'b1; tick(); rx_valid = 1'b0; stop = 1'b0;
    idle(3);
    check_writes("stop_rx_no_write");
    send(8'h77, 1'b0, "stop_rx_idle");
    check_writes("stop_rx_idle_write");

    // start wins over a coinciding data byte; that byte is not decoded.
    pulse_start();
    send(8'hA0, 1'b1, "st_ctrl");
    send(8'h05, 1'b1, "st_hi");
    send(8'h20, 1'b1, "st_lo");
    rx_byte = 8'h55; rx_valid = 1'b1; start = 1'b1; tick(); rx_valid = 1'b0; start = 1'b0;
    idle(3);
    chk("st_rx_ack", ack_out, 1'b0);
    send(8'hA0, 1'b1, "st_ctrl2");
    send(8'h06, 1'b1, "st_hi2");
    send(8'h40, 1'b1, "st_lo2");
    m_set_addr(8'h06, 8'h40);
    send(8'hE4, 1'b1, "st_data");
    m_write(8'hE4);
    pulse_stop();
    check_writes("start_rx");

    // Random mix of writes, random reads and current-address reads.
    for (int it = 0; it < 24; it++) begin
      case ($urandom_range(0, 2))
        0: begin
          n = $urandom_range(1, 6);
          for (int i = 0; i < n; i++) wr_buf[i] = 8'($urandom);
          wr_txn(8'($urandom), 8'($urandom), n);
        end
        1: begin
          hi = 8'($urandom); lo = 8'($urandom);
          pulse_start();
          send(8'hA0 | jit(), 1'b1, "rnd_ctrl_w");
          send(hi, 1'b1, "rnd_hi");
          send(lo, 1'b1, "rnd_lo");
          m_set_addr(hi, lo);
          pulse_start();
          rd_cur($urandom_range(1, 5));
        end
        default: begin
          pulse_start();
          rd_cur($urandom_range(1, 5));
        end
      endcase
    end
    check_writes("rnd_read_no_write");

    // Reset asserted while a write strobe is high kills it at once.
    pulse_start();
    send(8'hA0, 1'b1, "rw_ctrl");
    send(8'h0A, 1'b1, "rw_hi");
    send(8'hBC, 1'b1, "rw_lo");
    rx_byte = 8'hD2; rx_valid = 1'b1; tick(); rx_valid = 1'b0;
    chk("rw_we_high", mem_we, 1'b1);
    reset_n = 1'b0; #1;
    chk("rw_we_killed", mem_we, 1'b0);
    chk("rw_addr_cleared", mem_addr, 0);
    idle(2); reset_n = 1'b1; idle(2);
    m_addr = 0;
    check_writes("rst_write");

    // Reset in the middle of a read, then a current-address read starts at 0.
    hi = 8'($urandom); lo = 8'($urandom) | 8'h01;
    pulse_start();
    send(8'hA0, 1'b1, "rm_ctrl_w");
    send(hi, 1'b1, "rm_hi");
    send(lo, 1'b1, "rm_lo");
    pulse_start();
    send(8'hA1, 1'b1, "rm_ctrl_r");
    chk("rm_valid", tx_valid, 1'b1);
    reset_n = 1'b0; #1;
    chk("rm_valid_killed", tx_valid, 1'b0);
    chk("rm_byte_cleared", tx_byte, 8'h00);
    idle(2); reset_n = 1'b1; idle(2);
    m_addr = 0;
    pulse_start();
    rd_cur(2);
    check_writes("final_no_write");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
